// File: rtl/clk_wiz_lock_sequencer.sv
// rtl/clk_wiz_lock_sequencer.sv - ADPLL reset/lock sequencer with staggered output clock gate enables
module clk_wiz_lock_sequencer #(
    parameter int NUM_CLKS     = 6,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_FILTER  = 64,
    parameter int STAGGER      = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                clk_in1,
    input  logic                reset,
    input  logic                enable_req,
    input  logic [NUM_CLKS-1:0] clk_mask,
    input  logic                locked,
    input  logic                clear_status,
    output logic                pll_reset,
    output logic [NUM_CLKS-1:0] clk_gate_en,
    output logic                ready,
    output logic                lock_lost,
    output logic [3:0]          retry_cnt
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int SW = $clog2(STAGGER + 1);
    localparam int IW = $clog2(NUM_CLKS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PLL_RST, S_WAIT_LOCK, S_FILTER, S_ENABLE, S_RUN, S_DISABLE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q;
    logic [RW-1:0]       rcnt_q, rcnt_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [FW-1:0]       flt_q, flt_d;
    logic [SW-1:0]       stg_q, stg_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NUM_CLKS-1:0] mask_q, mask_d;
    logic [NUM_CLKS-1:0] gate_q, gate_d;
    logic                pll_reset_q, ready_q, lost_q;
    logic [3:0]          retry_q;
    logic                set_lost, retry_inc;
    logic                lock_s;

    assign lock_s = sync_q[1];

    // Shutdown walks only the gates that are actually on, highest first.
    function automatic logic [NUM_CLKS-1:0] drop_top(input logic [NUM_CLKS-1:0] g);
        logic [NUM_CLKS-1:0] r;
        logic                done;
        r    = g;
        done = 1'b0;
        for (int i = NUM_CLKS - 1; i >= 0; i--) begin
            if (g[i] && !done) begin
                r[i] = 1'b0;
                done = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        tmr_d     = tmr_q;
        flt_d     = flt_q;
        stg_d     = stg_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        gate_d    = gate_q;
        set_lost  = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                gate_d = '0;
                if (enable_req) begin
                    state_d = S_PLL_RST;
                    rcnt_d  = '0;
                end
            end
            S_PLL_RST: begin
                tmr_d = '0;
                flt_d = '0;
                if (!enable_req)                         state_d = S_IDLE;
                else if (rcnt_q == RW'(RST_CYCLES - 1))  state_d = S_WAIT_LOCK;
                else                                     rcnt_d  = rcnt_q + 1'b1;
            end
            S_WAIT_LOCK, S_FILTER: begin
                // flt_q is zero in WAIT_LOCK, so the first locked sample counts as one.
                tmr_d = tmr_q + 1'b1;
                if (!enable_req) begin
                    state_d = S_IDLE;
                end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
                    state_d   = S_PLL_RST;
                    rcnt_d    = '0;
                    retry_inc = 1'b1;
                end else if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    flt_d   = '0;
                end else if (flt_q == FW'(LOCK_FILTER - 1)) begin
                    state_d   = S_ENABLE;
                    mask_d    = clk_mask;
                    gate_d    = '0;
                    gate_d[0] = clk_mask[0];
                    idx_d     = IW'(1);
                    stg_d     = '0;
                end else begin
                    state_d = S_FILTER;
                    flt_d   = flt_q + 1'b1;
                end
            end
            default: begin
                if (!lock_s) begin
                    state_d   = enable_req ? S_PLL_RST : S_IDLE;
                    rcnt_d    = '0;
                    gate_d    = '0;
                    set_lost  = 1'b1;
                    retry_inc = 1'b1;
                end else if (state_q != S_DISABLE && !enable_req) begin
                    state_d = S_DISABLE;
                    gate_d  = drop_top(gate_q);
                    stg_d   = '0;
                end else if (state_q == S_ENABLE) begin
                    if (idx_q == IW'(NUM_CLKS)) begin
                        state_d = S_RUN;
                    end else if (stg_q == SW'(STAGGER - 1)) begin
                        gate_d[idx_q] = mask_q[idx_q];
                        idx_d         = idx_q + 1'b1;
                        stg_d         = '0;
                    end else begin
                        stg_d = stg_q + 1'b1;
                    end
                end else if (state_q == S_DISABLE) begin
                    if (gate_q == '0) begin
                        state_d = S_IDLE;
                    end else if (stg_q == SW'(STAGGER - 1)) begin
                        gate_d = drop_top(gate_q);
                        stg_d  = '0;
                    end else begin
                        stg_d = stg_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync_q      <= '0;
            rcnt_q      <= '0;
            tmr_q       <= '0;
            flt_q       <= '0;
            stg_q       <= '0;
            idx_q       <= '0;
            mask_q      <= '0;
            gate_q      <= '0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            lost_q      <= 1'b0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], locked};
            rcnt_q      <= rcnt_d;
            tmr_q       <= tmr_d;
            flt_q       <= flt_d;
            stg_q       <= stg_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            gate_q      <= gate_d;
            pll_reset_q <= (state_d == S_IDLE) || (state_d == S_PLL_RST);
            ready_q     <= (state_d == S_RUN);
            // A set or increment in the same cycle as clear_status takes priority.
            if (set_lost)          lost_q <= 1'b1;
            else if (clear_status) lost_q <= 1'b0;
            if (retry_inc)         retry_q <= (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
            else if (clear_status) retry_q <= '0;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign clk_gate_en = gate_q;
    assign ready       = ready_q;
    assign lock_lost   = lost_q;
    assign retry_cnt   = retry_q;
endmodule
